// File: rtl/wam_pkg.sv
// wam_pkg: shared constants, types and BCD helpers for the whack-a-mole
// player-input block (wam_hit and its debouncer wam_deb).
package wam_pkg;

  localparam int NUM_HOLES = 8;

  typedef logic [3:0] bcd_t;

  localparam logic [11:0] SCORE_MAX = 12'h999;

  // Number of set bits in a hole vector (0..8).
  function automatic logic [3:0] popcount(input logic [NUM_HOLES-1:0] v);
    logic [3:0] c;
    c = 4'd0;
    for (int i = 0; i < NUM_HOLES; i++) begin
      c = c + {3'b000, v[i]};
    end
    return c;
  endfunction

  // Add n (0..8) to a 3-digit BCD score with decimal carry; clamp at 999.
  function automatic logic [11:0] bcd_add_clamp(input logic [11:0] s, input logic [3:0] n);
    logic [4:0]  ones;
    logic [4:0]  tens;
    logic [4:0]  hund;
    logic [11:0] r;
    ones = {1'b0, s[3:0]} + {1'b0, n};
    tens = {1'b0, s[7:4]};
    hund = {1'b0, s[11:8]};
    if (ones >= 5'd10) begin
      ones = ones - 5'd10;
      tens = tens + 5'd1;
    end else begin
      ones = ones;
    end
    if (tens >= 5'd10) begin
      tens = tens - 5'd10;
      hund = hund + 5'd1;
    end else begin
      tens = tens;
    end
    if (hund >= 5'd10) begin
      r = SCORE_MAX;
    end else begin
      r = {hund[3:0], tens[3:0], ones[3:0]};
    end
    return r;
  endfunction

  // Subtract 1 from a 3-digit BCD score with decimal borrow; floor at 000.
  function automatic logic [11:0] bcd_dec_floor(input logic [11:0] s);
    bcd_t        o;
    bcd_t        t;
    bcd_t        h;
    logic [11:0] r;
    o = s[3:0];
    t = s[7:4];
    h = s[11:8];
    if (s == 12'h000) begin
      r = 12'h000;
    end else begin
      if (o != 4'd0) begin
        o = o - 4'd1;
      end else begin
        o = 4'd9;
        if (t != 4'd0) begin
          t = t - 4'd1;
        end else begin
          t = 4'd9;
          h = h - 4'd1;
        end
      end
      r = {h, t, o};
    end
    return r;
  endfunction

endpackage

// File: rtl/wam_hit_if.sv
// wam_hit_if: player-side bus of wam_hit. The master drives buttons, mole
// map and game controls; the slave (wam_hit) returns pulses and score.
interface wam_hit_if;
  import wam_pkg::*;

  logic [NUM_HOLES-1:0] btn;
  logic [NUM_HOLES-1:0] holes;
  logic                 en;
  logic                 clr;
  logic [NUM_HOLES-1:0] hit;
  logic                 miss;
  logic [11:0]          score;
  logic                 sat;

  modport master (output btn, holes, en, clr, input hit, miss, score, sat);
  modport slave  (input btn, holes, en, clr, output hit, miss, score, sat);
endinterface

// File: rtl/wam_deb.sv
// wam_deb: one-bit 2-flop synchronizer, debouncer and rising-edge detector.
// A new level is accepted after DB_CYCLES consecutive differing samples.
module wam_deb #(
  parameter int DB_CYCLES = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic rise
);

  localparam logic [7:0] DB_LAST = 8'(DB_CYCLES - 1);

  logic       meta;
  logic       sync;
  logic       lvl;
  logic       lvl_d;
  logic [7:0] cnt;

  // Bring the asynchronous button into the clk domain.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta <= 1'b0;
      sync <= 1'b0;
    end else begin
      meta <= din;
      sync <= meta;
    end
  end

  // Accept a new level only after DB_CYCLES consecutive differing samples.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lvl <= 1'b0;
      cnt <= 8'd0;
    end else if (sync == lvl) begin
      cnt <= 8'd0;
    end else if (cnt == DB_LAST) begin
      lvl <= ~lvl;
      cnt <= 8'd0;
    end else begin
      cnt <= cnt + 8'd1;
    end
  end

  // Remember the previous stable level for rise detection.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lvl_d <= 1'b0;
    end else begin
      lvl_d <= lvl;
    end
  end

  assign rise = lvl & ~lvl_d;

endmodule

// File: rtl/wam_hit.sv
// wam_hit: debounces the eight hole buttons, judges each press against the
// raised moles and keeps the saturating 3-digit BCD score.
// Optional feature macro: WAM_PENALTY_EN -- a miss cycle subtracts one point
// (floored at 000) after the hit addition.
module wam_hit
  import wam_pkg::*;
#(
  parameter int DB_CYCLES = 4
) (
  input logic       clk,
  input logic       rst,
  wam_hit_if.slave  bus
);

  logic [NUM_HOLES-1:0] rise;
  logic [NUM_HOLES-1:0] hit_n;
  logic                 miss_n;
  logic [11:0]          sum;
  logic [11:0]          score_n;
  logic [NUM_HOLES-1:0] hit_q;
  logic                 miss_q;
  logic [11:0]          score_q;
  logic                 sat_q;

  for (genvar i = 0; i < NUM_HOLES; i++) begin : g_deb
    wam_deb #(.DB_CYCLES(DB_CYCLES)) u_deb (
      .clk  (clk),
      .rst  (rst),
      .din  (bus.btn[i]),
      .rise (rise[i])
    );
  end

  // Judge press events and compute the next score; clr dominates, en gates.
  always_comb begin
    hit_n   = {NUM_HOLES{1'b0}};
    miss_n  = 1'b0;
    sum     = score_q;
    score_n = score_q;
    if (bus.clr) begin
      score_n = 12'h000;
    end else if (bus.en) begin
      hit_n  = rise & bus.holes;
      miss_n = |(rise & ~bus.holes);
      sum    = bcd_add_clamp(score_q, popcount(hit_n));
`ifdef WAM_PENALTY_EN
      if (miss_n) begin
        score_n = bcd_dec_floor(sum);
      end else begin
        score_n = sum;
      end
`else
      score_n = sum;
`endif
    end else begin
      score_n = score_q;
    end
  end

  // Register pulses, score and saturation flag together.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hit_q   <= {NUM_HOLES{1'b0}};
      miss_q  <= 1'b0;
      score_q <= 12'h000;
      sat_q   <= 1'b0;
    end else begin
      hit_q   <= hit_n;
      miss_q  <= miss_n;
      score_q <= score_n;
      sat_q   <= (score_n == SCORE_MAX);
    end
  end

  assign bus.hit   = hit_q;
  assign bus.miss  = miss_q;
  assign bus.score = score_q;
  assign bus.sat   = sat_q;

endmodule

// File: tb/tb_wam_hit.sv
// tb_wam_hit: directed stimulus for wam_hit with a cycle-level behavioural
// model (sample history window, integer score) checked every cycle, plus
// hand-computed literal expectations for latency, pulses and score.
module tb_wam_hit;
  import wam_pkg::*;

  localparam int DB = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_pass = 0;
  int   n_total = 0;

  wam_hit_if bus();

  wam_hit #(.DB_CYCLES(DB)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  function automatic void chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got %0h expected %0h at %0t", nm, got, exp, $time);
    end
  endfunction

  function automatic logic [11:0] to_bcd(input int v);
    return {4'(v / 100), 4'((v / 10) % 10), 4'(v % 10)};
  endfunction

  // Behavioural model: raw button history, stable levels, pending rises.
  logic [7:0] m_raw [0:DB+1];
  logic [7:0] m_lvl = 8'h00;
  logic [7:0] m_nl = 8'h00;
  logic [7:0] m_pend = 8'h00;
  logic       m_all;
  logic [7:0] exp_hit = 8'h00;
  logic       exp_miss = 1'b0;
  int         exp_score = 0;

  // A level changes once the last DB synchronized samples (raw btn delayed
  // two edges) all disagree with it; a rise is judged on the following edge.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int j = 0; j <= DB + 1; j++) m_raw[j] = 8'h00;
      m_lvl = 8'h00; m_pend = 8'h00;
      exp_hit = 8'h00; exp_miss = 1'b0; exp_score = 0;
    end else begin
      if (bus.clr) begin
        exp_hit = 8'h00; exp_miss = 1'b0; exp_score = 0;
      end else if (bus.en) begin
        exp_hit  = m_pend & bus.holes;
        exp_miss = (m_pend & ~bus.holes) != 8'h00;
        exp_score = exp_score + $countones(exp_hit);
        if (exp_score > 999) exp_score = 999;
`ifdef WAM_PENALTY_EN
        if (exp_miss && exp_score > 0) exp_score = exp_score - 1;
`endif
      end else begin
        exp_hit = 8'h00; exp_miss = 1'b0;
      end
      for (int j = DB + 1; j > 0; j--) m_raw[j] = m_raw[j-1];
      m_raw[0] = bus.btn;
      for (int i = 0; i < 8; i++) begin
        m_all = 1'b1;
        for (int j = 2; j <= DB + 1; j++) if (m_raw[j][i] == m_lvl[i]) m_all = 1'b0;
        m_nl[i] = m_all ? ~m_lvl[i] : m_lvl[i];
      end
      m_pend = m_nl & ~m_lvl;
      m_lvl  = m_nl;
    end
  end

  // Compare every output against the model once per cycle.
  always @(negedge clk) begin
    chk("hit", 32'(bus.hit), 32'(exp_hit));
    chk("miss", 32'(bus.miss), 32'(exp_miss));
    chk("score", 32'(bus.score), 32'(to_bcd(exp_score)));
    chk("sat", 32'(bus.sat), 32'(exp_score == 999));
  end

  // Press mask with mole map hv for hold cycles, then release; report the
  // first pulse (latency in cycles, hit, miss) and the number of pulse cycles.
  task automatic press(input logic [7:0] mask, input logic [7:0] hv, input int hold,
                       output int lat, output logic [7:0] h, output logic m, output int np);
    lat = 0; h = 8'h00; m = 1'b0; np = 0;
    @(negedge clk); #1;
    bus.btn = mask; bus.holes = hv;
    for (int c = 1; c <= hold; c++) begin
      @(negedge clk);
      if (bus.hit != 8'h00 || bus.miss) begin
        np++;
        if (lat == 0) begin lat = c; h = bus.hit; m = bus.miss; end
      end
    end
    #1; bus.btn = 8'h00;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      if (bus.hit != 8'h00 || bus.miss) np++;
    end
  endtask

  int         lat;
  int         np;
  logic [7:0] h;
  logic       m;

  initial begin
    bus.btn = 8'h00; bus.holes = 8'h00; bus.en = 1'b0; bus.clr = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset_hit", 32'(bus.hit), 32'h0);
    chk("reset_score", 32'(bus.score), 32'h000);
    chk("reset_sat", 32'(bus.sat), 32'h0);
    #1; rst = 1'b0; bus.en = 1'b1;
    repeat (2) @(negedge clk);

    // Single hit: latency 7, one pulse, score 001.
    press(8'h01, 8'h01, 20, lat, h, m, np);
    chk("single_lat", 32'(lat), 32'd7);
    chk("single_hit", 32'(h), 32'h01);
    chk("single_miss", 32'(m), 32'h0);
    chk("single_npulse", 32'(np), 32'd1);
    chk("single_score", 32'(bus.score), 32'h001);
    chk("model_score_1", 32'(exp_score), 32'd1);

    // Glitch of 3 cycles is ignored.
    press(8'h08, 8'h08, 3, lat, h, m, np);
    chk("glitch_npulse", 32'(np), 32'd0);
    chk("glitch_score", 32'(bus.score), 32'h001);

    // Simultaneous presses: two hits and one miss in the same cycle.
    press(8'h3C, 8'h0F, 20, lat, h, m, np);
    chk("simul_lat", 32'(lat), 32'd7);
    chk("simul_hit", 32'(h), 32'h0C);
    chk("simul_miss", 32'(m), 32'h1);
    chk("simul_npulse", 32'(np), 32'd1);
`ifdef WAM_PENALTY_EN
    chk("simul_score", 32'(bus.score), 32'h002);
`else
    chk("simul_score", 32'(bus.score), 32'h003);
`endif

    // Reset mid-debounce with the button held: fresh press afterwards.
    @(negedge clk); #1;
    bus.btn = 8'h02; bus.holes = 8'h02;
    repeat (4) @(negedge clk);
    #1; rst = 1'b1;
    repeat (2) @(negedge clk);
    chk("rst_mid_hit", 32'(bus.hit), 32'h0);
    chk("rst_mid_score", 32'(bus.score), 32'h000);
    #1; rst = 1'b0;
    lat = 0; h = 8'h00;
    for (int c = 1; c <= 20; c++) begin
      @(negedge clk);
      if (lat == 0 && bus.hit != 8'h00) begin lat = c; h = bus.hit; end
    end
    chk("rst_fresh_lat", 32'(lat), 32'd7);
    chk("rst_fresh_hit", 32'(h), 32'h02);
    chk("rst_fresh_score", 32'(bus.score), 32'h001);
    #1; bus.btn = 8'h00;
    repeat (12) @(negedge clk);

    // en=0: press dropped.
    #1; bus.en = 1'b0;
    press(8'h01, 8'h01, 20, lat, h, m, np);
    chk("en0_npulse", 32'(np), 32'd0);
    chk("en0_score", 32'(bus.score), 32'h001);
    #1; bus.en = 1'b1;

    // clr in the event cycle: score cleared, no pulse.
    @(negedge clk); #1;
    bus.btn = 8'h01; bus.holes = 8'h01;
    repeat (6) @(negedge clk);
    #1; bus.clr = 1'b1;
    @(negedge clk);
    chk("clr_hit", 32'(bus.hit), 32'h0);
    chk("clr_score", 32'(bus.score), 32'h000);
    #1; bus.clr = 1'b0;
    @(negedge clk);
    chk("clr_after_hit", 32'(bus.hit), 32'h0);
    #1; bus.btn = 8'h00;
    repeat (12) @(negedge clk);

    // Press on an empty hole at score 000: miss pulse, score stays 000.
    press(8'h01, 8'h00, 20, lat, h, m, np);
    chk("floor_lat", 32'(lat), 32'd7);
    chk("floor_miss", 32'(m), 32'h1);
    chk("floor_hit", 32'(h), 32'h00);
    chk("floor_score", 32'(bus.score), 32'h000);

    // BCD carry and saturation: 124*8 + 6 = 998, then +3 clamps at 999.
    for (int k = 0; k < 124; k++) press(8'hFF, 8'hFF, 8, lat, h, m, np);
    chk("pre_992", 32'(bus.score), 32'h992);
    press(8'h3F, 8'hFF, 8, lat, h, m, np);
    chk("pre_998", 32'(bus.score), 32'h998);
    chk("pre_998_sat", 32'(bus.sat), 32'h0);
    press(8'h07, 8'h07, 8, lat, h, m, np);
    chk("sat_hit", 32'(h), 32'h07);
    chk("sat_score", 32'(bus.score), 32'h999);
    chk("sat_flag", 32'(bus.sat), 32'h1);
    chk("model_score_999", 32'(exp_score), 32'd999);
    press(8'h01, 8'h01, 8, lat, h, m, np);
    chk("sat_hold_hit", 32'(h), 32'h01);
    chk("sat_hold_score", 32'(bus.score), 32'h999);
    chk("sat_hold_flag", 32'(bus.sat), 32'h1);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
